// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves branches from ALU flags, buffers entries
// in a 2-deep skid (main + skid), and pulses a fetch redirect for taken entries.
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            cf,
  input  logic            zf,
  input  logic            vf,
  input  logic            sf,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_target,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            is_branch,
  input  logic            is_jump,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
  } ent_t;

  ent_t r_main, r_skid, w_in;
  logic r_out_valid, r_skid_valid;
  logic r_redir_valid;
  logic [XLEN-1:0] r_redir_pc;
  logic w_cond, w_taken, w_bad_f3, w_accept, w_xfer;

  // Flags come from A+~B+1, so cf=1 means A>=B unsigned.
  always_comb begin
    w_cond   = 1'b0;
    w_bad_f3 = 1'b0;
    case (funct3)
      3'b000:  w_cond = zf;
      3'b001:  w_cond = ~zf;
      3'b100:  w_cond = sf ^ vf;
      3'b101:  w_cond = ~(sf ^ vf);
      3'b110:  w_cond = ~cf;
      3'b111:  w_cond = cf;
      default: w_bad_f3 = 1'b1;
    endcase
  end

  assign w_taken = is_jump | (is_branch & w_cond);

  always_comb begin
    w_in            = '0;
    w_in.result     = is_jump ? pc_plus4 : alu_result;
    w_in.store_data = rs2_data;
    w_in.rd         = rd;
    w_in.funct3     = funct3;
    w_in.reg_write  = reg_write;
    w_in.mem_read   = mem_read;
    w_in.mem_write  = mem_write;
    w_in.illegal    = is_branch & w_bad_f3;
  end

  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_xfer   = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid && w_xfer) begin
      r_main       <= r_skid;
      r_skid_valid <= 1'b0;
    end else if (w_accept && (!r_out_valid || out_ready)) begin
      r_main      <= w_in;
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Redirect is taken at accept time, independent of downstream backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_redir_valid <= w_accept & w_taken;
      if (w_accept && w_taken) r_redir_pc <= branch_target;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_main.result;
  assign out_store_data = r_main.store_data;
  assign out_rd         = r_main.rd;
  assign out_funct3     = r_main.funct3;
  assign out_reg_write  = r_main.reg_write;
  assign out_mem_read   = r_main.mem_read;
  assign out_mem_write  = r_main.mem_write;
  assign out_illegal    = r_main.illegal;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic, checked
// against a 2-deep FIFO model whose branch outcome comes from operand compares.
module tb_ex_mem_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [XLEN-1:0] alu_result = '0, rs2_data = '0, pc_plus4 = '0, branch_target = '0;
  logic cf = 1'b0, zf = 1'b0, vf = 1'b0, sf = 1'b0;
  logic [4:0] rd = '0;
  logic [2:0] funct3 = '0;
  logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [XLEN-1:0] out_result, out_store_data, redirect_pc;
  logic [4:0] out_rd;
  logic [2:0] out_funct3;
  logic out_reg_write, out_mem_read, out_mem_write, out_illegal, redirect_valid;

  ex_mem_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .cf(cf), .zf(zf), .vf(vf), .sf(sf), .rs2_data(rs2_data),
    .pc_plus4(pc_plus4), .branch_target(branch_target), .rd(rd), .funct3(funct3),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .is_branch(is_branch), .is_jump(is_jump), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_illegal(out_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result, sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  ctrl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  logic exp_redir = 1'b0;
  logic [31:0] exp_rpc = '0;
  logic [31:0] op_a = '0, op_b = '0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive the ALU as it would compute A-B, flags included.
  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    op_a = a; op_b = b;
    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    alu_result = s[31:0];
    cf = s[32];
    zf = (s[31:0] == 32'd0);
    sf = s[31];
    vf = (a[31] != b[31]) && (s[31] != a[31]);
  endtask

  function automatic logic model_taken();
    if (is_jump) return 1'b1;
    if (!is_branch) return 1'b0;
    case (funct3)
      3'd0: return op_a == op_b;
      3'd1: return op_a != op_b;
      3'd4: return $signed(op_a) < $signed(op_b);
      3'd5: return $signed(op_a) >= $signed(op_b);
      3'd6: return op_a < op_b;
      3'd7: return op_a >= op_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_redir});
    if (exp_redir) chk("redirect_pc", redirect_pc, exp_rpc);
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_store_data", out_store_data, q[0].sd);
      chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
      chk("out_funct3", {29'd0, out_funct3}, {29'd0, q[0].f3});
      chk("out_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, {29'd0, q[0].ctrl});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
    end
  endtask

  // One clock: advance the FIFO model with the current inputs, then compare.
  task automatic tick();
    logic acc, pop, tk;
    exp_t e;
    acc = in_valid && (q.size() < 2) && !flush;
    pop = (q.size() > 0) && out_ready;
    tk  = model_taken();
    e.result = is_jump ? pc_plus4 : alu_result;
    e.sd = rs2_data; e.rd = rd; e.f3 = funct3;
    e.ctrl = {reg_write, mem_read, mem_write};
    e.ill = is_branch && (funct3 == 3'd2 || funct3 == 3'd3);
    @(posedge clk);
    if (flush) begin
      q.delete();
      exp_redir = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      exp_redir = acc && tk;
      if (acc && tk) exp_rpc = branch_target;
    end
    #1 check_outputs();
  endtask

  task automatic plain(input logic [31:0] val);
    in_valid = 1'b1; is_branch = 1'b0; is_jump = 1'b0; funct3 = 3'd0;
    reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    rs2_data = val ^ 32'h5555_0000; rd = val[4:0];
    set_ops(val, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Streaming, 1..4 back to back
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      plain(i); tick();
      chk("stream_result", out_result, i);
    end
    in_valid = 1'b0; tick();

    // Backpressure: 0xA in main, 0xB in skid
    out_ready = 1'b0;
    plain(32'hA); tick();
    plain(32'hB); tick();
    in_valid = 1'b0; tick();
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    chk("bp_second", out_result, 32'hB);
    tick();
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);

    // BLT taken (sf=1, vf=0)
    plain(0); is_branch = 1'b1; reg_write = 1'b0; funct3 = 3'd4;
    branch_target = 32'h100; set_ops(32'd1, 32'd2); tick();
    chk("blt_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("blt_target", redirect_pc, 32'h100);
    // BGEU with cf=0, not taken
    funct3 = 3'd7; branch_target = 32'h200; tick();
    chk("bgeu_no_redirect", {31'd0, redirect_valid}, 32'd0);
    // JAL
    plain(0); is_jump = 1'b1; pc_plus4 = 32'h24; branch_target = 32'h80; tick();
    chk("jal_result", out_result, 32'h24);
    chk("jal_target", redirect_pc, 32'h80);
    // Branch with funct3=010
    plain(0); is_branch = 1'b1; funct3 = 3'd2; set_ops(32'd3, 32'd3); tick();
    chk("illegal_flag", {31'd0, out_illegal}, 32'd1);
    chk("illegal_no_redirect", {31'd0, redirect_valid}, 32'd0);
    in_valid = 1'b0; tick();

    // Flush with skid full and a taken branch being offered
    out_ready = 1'b0;
    plain(32'h11); tick();
    plain(32'h12); is_jump = 1'b1; branch_target = 32'h300; tick();
    plain(32'h13); is_branch = 1'b1; funct3 = 3'd0; set_ops(32'd5, 32'd5);
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Asynchronous reset with main+skid full and a redirect pending
    out_ready = 1'b0;
    plain(32'h21); tick();
    plain(32'h22); is_jump = 1'b1; branch_target = 32'h400; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete(); exp_redir = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      is_branch = (kind == 1);
      is_jump   = (kind == 2);
      funct3    = 3'($urandom_range(0, 7));
      reg_write = (kind != 1) && $urandom_range(0, 1) == 1;
      mem_read  = (kind == 3) && $urandom_range(0, 1) == 1;
      mem_write = (kind == 3) && !mem_read;
      rd = 5'($urandom); rs2_data = $urandom;
      pc_plus4 = $urandom; branch_target = $urandom;
      if ($urandom_range(0, 3) == 0) set_ops(32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      else set_ops($urandom, $urandom);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
